// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
//
// Purpose:
//   Data-hazard detector for a five-stage in-order pipeline. It tracks the
//   destination of the instructions now in EXE and MEM and compares it with
//   the sources of the instruction in ID. On a hazard it requests a stall:
//   the controller, IF/ID and the PC hold, and a bubble is sent into EXE.
//   A taken branch squashes the ID instruction and overrides any stall.
//
// Ports:
//   i_clk               clock, rising edge
//   i_rst               synchronous active-high reset
//   i_forward_en        1 = EXE forwarding path present (only load-use stalls)
//   i_id_valid          ID stage holds a real instruction
//   i_src1, i_src2      source registers of the ID instruction
//   i_two_src           the ID instruction actually reads i_src2
//   i_id_wb_en          ID instruction writes back a register
//   i_id_mem_r_en       ID instruction is a load
//   i_id_dest           destination register of the ID instruction
//   i_branch_taken      squash the ID instruction (flush)
//   o_hazard_detected   combinational stall request
//   o_exe_dest          tracked EXE destination (0 for a bubble)
//   o_mem_dest          tracked MEM destination (0 for a bubble)
//   o_stall_cnt         saturating count of stalled cycles since reset
// -----------------------------------------------------------------------------
module hazard_unit #(
    parameter int REG_ADDR_LEN = 5,
    parameter int CNT_LEN      = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_forward_en,
    input  logic                    i_id_valid,
    input  logic [REG_ADDR_LEN-1:0] i_src1,
    input  logic [REG_ADDR_LEN-1:0] i_src2,
    input  logic                    i_two_src,
    input  logic                    i_id_wb_en,
    input  logic                    i_id_mem_r_en,
    input  logic [REG_ADDR_LEN-1:0] i_id_dest,
    input  logic                    i_branch_taken,
    output logic                    o_hazard_detected,
    output logic [REG_ADDR_LEN-1:0] o_exe_dest,
    output logic [REG_ADDR_LEN-1:0] o_mem_dest,
    output logic [CNT_LEN-1:0]      o_stall_cnt
);

    localparam logic [CNT_LEN-1:0] CNT_MAX = {CNT_LEN{1'b1}};
    localparam logic [CNT_LEN-1:0] CNT_ONE = {{(CNT_LEN-1){1'b0}}, 1'b1};

    // EXE slot: full {wb_en, mem_r_en, dest}.
    logic                    r_exe_wb_en;
    logic                    r_exe_mem_r_en;
    logic [REG_ADDR_LEN-1:0] r_exe_dest;
    // MEM slot: a load in MEM already has its data available, so the
    // mem_r_en flag of this slot never influences a decision and is not kept.
    logic                    r_mem_wb_en;
    logic [REG_ADDR_LEN-1:0] r_mem_dest;
    logic [CNT_LEN-1:0]      r_stall_cnt;

    logic w_s1_exe;
    logic w_s1_mem;
    logic w_s2_exe;
    logic w_s2_mem;
    logic w_raw_hazard;
    logic w_hazard;
    logic w_exe_load;

    // A source hits a slot when it names a real register the slot will write.
    // Register 0 is hard-wired, so it can never create a dependency.
    function automatic logic src_hit(
        input logic [REG_ADDR_LEN-1:0] src,
        input logic                    slot_wb_en,
        input logic [REG_ADDR_LEN-1:0] slot_dest
    );
        return (src != {REG_ADDR_LEN{1'b0}}) && slot_wb_en && (slot_dest == src);
    endfunction

    assign w_s1_exe = src_hit(i_src1, r_exe_wb_en, r_exe_dest);
    assign w_s1_mem = src_hit(i_src1, r_mem_wb_en, r_mem_dest);
    // src2 only counts when the instruction really reads it.
    assign w_s2_exe = i_two_src & src_hit(i_src2, r_exe_wb_en, r_exe_dest);
    assign w_s2_mem = i_two_src & src_hit(i_src2, r_mem_wb_en, r_mem_dest);

    // Raw hazard: with forwarding only a load in EXE cannot be bypassed in
    // time; without forwarding any pending write in EXE or MEM must drain.
    always_comb begin
        w_raw_hazard = 1'b0;
        if (!i_id_valid) begin
            w_raw_hazard = 1'b0;
        end else if (i_forward_en) begin
            w_raw_hazard = r_exe_mem_r_en & (w_s1_exe | w_s2_exe);
        end else begin
            w_raw_hazard = w_s1_exe | w_s1_mem | w_s2_exe | w_s2_mem;
        end
    end

    // A flush discards the ID instruction, so stalling for it is pointless.
    assign w_hazard   = w_raw_hazard & ~i_branch_taken;
    assign w_exe_load = i_id_valid & ~w_hazard & ~i_branch_taken;

    // Scoreboard shift (ID -> EXE -> MEM) and saturating stall counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_exe_wb_en    <= 1'b0;
            r_exe_mem_r_en <= 1'b0;
            r_exe_dest     <= {REG_ADDR_LEN{1'b0}};
            r_mem_wb_en    <= 1'b0;
            r_mem_dest     <= {REG_ADDR_LEN{1'b0}};
            r_stall_cnt    <= {CNT_LEN{1'b0}};
        end else begin
            r_mem_wb_en <= r_exe_wb_en;
            r_mem_dest  <= r_exe_dest;
            if (w_exe_load) begin
                r_exe_wb_en    <= i_id_wb_en;
                r_exe_mem_r_en <= i_id_mem_r_en;
                r_exe_dest     <= i_id_dest;
            end else begin
                r_exe_wb_en    <= 1'b0;
                r_exe_mem_r_en <= 1'b0;
                r_exe_dest     <= {REG_ADDR_LEN{1'b0}};
            end
            if (w_hazard && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
        end
    end

    assign o_hazard_detected = w_hazard;
    assign o_exe_dest        = r_exe_dest;
    assign o_mem_dest        = r_mem_dest;
    assign o_stall_cnt       = r_stall_cnt;

endmodule

// File: tb/tb_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_unit
//
// Self-checking bench for hazard_unit. A behavioural pipeline model predicts
// every cycle's outputs; the prediction is queued when the stimulus is driven
// and popped and compared when the outputs are sampled. A second instance with
// a 3-bit counter shares all inputs so counter saturation is reached quickly.
// -----------------------------------------------------------------------------
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       forward_en;
    logic       id_valid;
    logic [4:0] src1;
    logic [4:0] src2;
    logic       two_src;
    logic       id_wb_en;
    logic       id_mem_r_en;
    logic [4:0] id_dest;
    logic       branch_taken;

    logic        hazard_detected;
    logic [4:0]  exe_dest;
    logic [4:0]  mem_dest;
    logic [15:0] stall_cnt;
    logic        hazard_detected_s;
    logic [4:0]  exe_dest_s;
    logic [4:0]  mem_dest_s;
    logic [2:0]  stall_cnt_s;

    always #5 clk = ~clk;

    hazard_unit #(.REG_ADDR_LEN(5), .CNT_LEN(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_forward_en(forward_en), .i_id_valid(id_valid),
        .i_src1(src1), .i_src2(src2), .i_two_src(two_src), .i_id_wb_en(id_wb_en),
        .i_id_mem_r_en(id_mem_r_en), .i_id_dest(id_dest), .i_branch_taken(branch_taken),
        .o_hazard_detected(hazard_detected), .o_exe_dest(exe_dest),
        .o_mem_dest(mem_dest), .o_stall_cnt(stall_cnt)
    );

    hazard_unit #(.REG_ADDR_LEN(5), .CNT_LEN(3)) dut_sat (
        .i_clk(clk), .i_rst(rst), .i_forward_en(forward_en), .i_id_valid(id_valid),
        .i_src1(src1), .i_src2(src2), .i_two_src(two_src), .i_id_wb_en(id_wb_en),
        .i_id_mem_r_en(id_mem_r_en), .i_id_dest(id_dest), .i_branch_taken(branch_taken),
        .o_hazard_detected(hazard_detected_s), .o_exe_dest(exe_dest_s),
        .o_mem_dest(mem_dest_s), .o_stall_cnt(stall_cnt_s)
    );

    typedef struct packed {
        logic        haz;
        logic [4:0]  exe;
        logic [4:0]  mem;
        logic [15:0] cnt;
        logic [2:0]  cnt_s;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference pipeline state.
    logic       m_exe_wb   = 1'b0;
    logic       m_exe_mr   = 1'b0;
    logic [4:0] m_exe_dest = 5'd0;
    logic       m_mem_wb   = 1'b0;
    logic [4:0] m_mem_dest = 5'd0;
    int         m_cnt      = 0;
    int         m_cnt_s    = 0;

    // Last sampled DUT outputs, for scenario-specific constant checks.
    logic       obs_haz;
    logic [4:0] obs_exe;
    logic [4:0] obs_mem;

    // Count one comparison and report it if the observed value is wrong.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic hit(input logic [4:0] s, input logic wb, input logic [4:0] d);
        return (s != 5'd0) && wb && (d == s);
    endfunction

    // One clock: apply inputs, predict, compare away from the edge, advance model.
    task automatic drive(input logic rst_v, input logic valid, input logic [4:0] s1,
                         input logic [4:0] s2, input logic two, input logic wb,
                         input logic mr, input logic [4:0] dst, input logic br,
                         input logic fe, input logic do_chk, output logic haz);
        exp_t e;
        exp_t g;
        logic raw;
        logic h1e, h1m, h2e, h2m;
        rst = rst_v; id_valid = valid; src1 = s1; src2 = s2; two_src = two;
        id_wb_en = wb; id_mem_r_en = mr; id_dest = dst; branch_taken = br;
        forward_en = fe;
        h1e = hit(s1, m_exe_wb, m_exe_dest);
        h1m = hit(s1, m_mem_wb, m_mem_dest);
        h2e = two && hit(s2, m_exe_wb, m_exe_dest);
        h2m = two && hit(s2, m_mem_wb, m_mem_dest);
        if (!valid)  raw = 1'b0;
        else if (fe) raw = m_exe_mr && (h1e || h2e);
        else         raw = h1e || h1m || h2e || h2m;
        haz     = raw && !br;
        e.haz   = haz;
        e.exe   = m_exe_dest;
        e.mem   = m_mem_dest;
        e.cnt   = m_cnt[15:0];
        e.cnt_s = m_cnt_s[2:0];
        if (do_chk) sb_q.push_back(e);
        #3;
        obs_haz = hazard_detected;
        obs_exe = exe_dest;
        obs_mem = mem_dest;
        if (do_chk) begin
            g = sb_q.pop_front();
            chk("hazard", {31'd0, hazard_detected}, {31'd0, g.haz});
            chk("exe_dest", {27'd0, exe_dest}, {27'd0, g.exe});
            chk("mem_dest", {27'd0, mem_dest}, {27'd0, g.mem});
            chk("stall_cnt", {16'd0, stall_cnt}, {16'd0, g.cnt});
            chk("sat_hazard", {31'd0, hazard_detected_s}, {31'd0, g.haz});
            chk("sat_exe_dest", {27'd0, exe_dest_s}, {27'd0, g.exe});
            chk("sat_mem_dest", {27'd0, mem_dest_s}, {27'd0, g.mem});
            chk("sat_stall_cnt", {29'd0, stall_cnt_s}, {29'd0, g.cnt_s});
        end
        if (rst_v) begin
            m_exe_wb = 1'b0; m_exe_mr = 1'b0; m_exe_dest = 5'd0;
            m_mem_wb = 1'b0; m_mem_dest = 5'd0; m_cnt = 0; m_cnt_s = 0;
        end else begin
            m_mem_wb   = m_exe_wb;
            m_mem_dest = m_exe_dest;
            if (valid && !haz && !br) begin
                m_exe_wb = wb; m_exe_mr = mr; m_exe_dest = dst;
            end else begin
                m_exe_wb = 1'b0; m_exe_mr = 1'b0; m_exe_dest = 5'd0;
            end
            if (haz) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt_s < 7) m_cnt_s++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic bubble(input int n, input logic fe);
        logic h;
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, fe, 1'b1, h);
    endtask

    // Hold an instruction in ID until it issues; returns the stall cycles seen.
    task automatic issue(input logic [4:0] s1, input logic [4:0] s2, input logic two,
                         input logic wb, input logic mr, input logic [4:0] dst,
                         input logic fe, output int stalls);
        logic h;
        logic done;
        stalls = 0;
        done   = 1'b0;
        for (int k = 0; k < 8 && !done; k++) begin
            drive(1'b0, 1'b1, s1, s2, two, wb, mr, dst, 1'b0, fe, 1'b1, h);
            if (h) stalls++;
            else   done = 1'b1;
        end
        if (!done) chk("issue_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  st;
        logic h;
        rst = 1'b1; forward_en = 1'b0; id_valid = 1'b0; src1 = 5'd0; src2 = 5'd0;
        two_src = 1'b0; id_wb_en = 1'b0; id_mem_r_en = 1'b0; id_dest = 5'd0;
        branch_taken = 1'b0;
        @(posedge clk);
        #1;
        // Reset: first cycle unknown state, second cycle checked reset values.
        drive(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, h);
        drive(1'b1, 1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0, 1'b1, h);
        // After reset no hazard for any ID instruction until a producer exists.
        drive(1'b0, 1'b1, 5'd3, 5'd4, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, h);
        chk("post_reset_haz", {31'd0, obs_haz}, 32'd0);
        bubble(2, 1'b0);

        // Scenario 1: ADD r3 ; SUB r4,r3,r5 without forwarding.
        issue(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd3, 1'b0, st);
        chk("s1_producer_stalls", st, 32'd0);
        drive(1'b0, 1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 1'b0, 5'd4, 1'b0, 1'b0, 1'b1, h);
        chk("s1_stall1", {31'd0, obs_haz}, 32'd1);
        drive(1'b0, 1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 1'b0, 5'd4, 1'b0, 1'b0, 1'b1, h);
        chk("s1_stall2", {31'd0, obs_haz}, 32'd1);
        chk("s1_exe_2nd", {27'd0, obs_exe}, 32'd0);
        chk("s1_mem_2nd", {27'd0, obs_mem}, 32'd3);
        drive(1'b0, 1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 1'b0, 5'd4, 1'b0, 1'b0, 1'b1, h);
        chk("s1_issue", {31'd0, obs_haz}, 32'd0);
        bubble(2, 1'b0);
        chk("s1_cnt", {16'd0, stall_cnt}, 32'd2);

        // Scenario 2: load-use with forwarding, then ALU producer.
        issue(5'd1, 5'd0, 1'b0, 1'b1, 1'b1, 5'd7, 1'b1, st);
        issue(5'd7, 5'd2, 1'b1, 1'b1, 1'b0, 5'd1, 1'b1, st);
        chk("s2_load_use_stalls", st, 32'd1);
        bubble(2, 1'b1);
        issue(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd7, 1'b1, st);
        issue(5'd7, 5'd2, 1'b1, 1'b1, 1'b0, 5'd1, 1'b1, st);
        chk("s2_alu_stalls", st, 32'd0);
        bubble(2, 1'b1);
        chk("s2_cnt", {16'd0, stall_cnt}, 32'd3);

        // Scenario 3: register 0 never creates a hazard.
        issue(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, st);
        issue(5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd6, 1'b0, st);
        chk("s3_r0_stalls", st, 32'd0);
        bubble(2, 1'b0);
        chk("s3_cnt", {16'd0, stall_cnt}, 32'd3);

        // Scenario 4: src2 matters only with two_src=1.
        issue(5'd1, 5'd0, 1'b0, 1'b1, 1'b0, 5'd5, 1'b0, st);
        issue(5'd2, 5'd5, 1'b0, 1'b1, 1'b0, 5'd6, 1'b0, st);
        chk("s4_one_src_stalls", st, 32'd0);
        bubble(2, 1'b0);
        issue(5'd1, 5'd0, 1'b0, 1'b1, 1'b0, 5'd5, 1'b0, st);
        issue(5'd2, 5'd5, 1'b1, 1'b1, 1'b0, 5'd6, 1'b0, st);
        chk("s4_two_src_stalls", st, 32'd2);
        bubble(2, 1'b0);
        chk("s4_cnt", {16'd0, stall_cnt}, 32'd5);

        // Scenario 5: flush beats hazard in the same cycle.
        issue(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd6, 1'b0, st);
        drive(1'b0, 1'b1, 5'd6, 5'd0, 1'b0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1, h);
        chk("s5_flush_haz", {31'd0, obs_haz}, 32'd0);
        bubble(1, 1'b0);
        chk("s5_exe_bubble", {27'd0, obs_exe}, 32'd0);
        chk("s5_cnt", {16'd0, stall_cnt}, 32'd5);
        bubble(2, 1'b0);

        // forward_en dropped to 1 mid-stall takes effect in that cycle.
        issue(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd8, 1'b0, st);
        drive(1'b0, 1'b1, 5'd8, 5'd0, 1'b0, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0, 1'b1, h);
        chk("fe_stall_first", {31'd0, obs_haz}, 32'd1);
        drive(1'b0, 1'b1, 5'd8, 5'd0, 1'b0, 1'b1, 1'b0, 5'd9, 1'b0, 1'b1, 1'b1, h);
        chk("fe_switch_release", {31'd0, obs_haz}, 32'd0);
        bubble(2, 1'b0);

        // One independent instruction between producer and consumer: 1 stall.
        issue(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd9, 1'b0, st);
        issue(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd12, 1'b0, st);
        issue(5'd9, 5'd0, 1'b0, 1'b1, 1'b0, 5'd13, 1'b0, st);
        chk("gap_stalls", st, 32'd1);
        bubble(2, 1'b0);
        chk("gap_cnt", {16'd0, stall_cnt}, 32'd7);

        // Dependent chain pushes the narrow counter past saturation.
        for (int k = 1; k <= 5; k++) begin
            issue(5'(10 + k - 1), 5'd0, 1'b0, 1'b1, 1'b0, 5'(10 + k), 1'b0, st);
            if (k > 1) chk("chain_stalls", st, 32'd2);
        end
        bubble(2, 1'b0);
        chk("chain_cnt", {16'd0, stall_cnt}, 32'd15);
        chk("sat_cnt_hold", {29'd0, stall_cnt_s}, 32'd7);

        // Reset asserted mid-stall ends the stall on the next edge.
        issue(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd3, 1'b0, st);
        drive(1'b0, 1'b1, 5'd3, 5'd0, 1'b0, 1'b1, 1'b0, 5'd4, 1'b0, 1'b0, 1'b1, h);
        chk("rst_pre_stall", {31'd0, obs_haz}, 32'd1);
        drive(1'b1, 1'b1, 5'd3, 5'd0, 1'b0, 1'b1, 1'b0, 5'd4, 1'b0, 1'b0, 1'b1, h);
        drive(1'b0, 1'b1, 5'd3, 5'd0, 1'b0, 1'b1, 1'b0, 5'd4, 1'b0, 1'b0, 1'b1, h);
        chk("rst_mid_haz", {31'd0, obs_haz}, 32'd0);
        chk("rst_mid_exe", {27'd0, obs_exe}, 32'd0);
        chk("rst_mid_mem", {27'd0, obs_mem}, 32'd0);
        bubble(2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter REG_ADDR_LEN, default 5, SHALL set the width of every register-address port.
REQ-002 Parameter CNT_LEN, default 16, SHALL set the width of the stall counter.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 forward_en  in  1  1 = forwarding path is present in EXE; 0 = no forwarding.
REQ-006 id_valid  in  1  the ID stage holds a real instruction.
REQ-007 src1  in  REG_ADDR_LEN  first source register of the ID instruction.
REQ-008 src2  in  REG_ADDR_LEN  second source register of the ID instruction.
REQ-009 two_src  in  1  the ID instruction reads src2 (register-register ALU op, ST or BNE).
REQ-010 id_wb_en  in  1  WB_EN decoded for the ID instruction.
REQ-011 id_mem_r_en  in  1  MEM_R_EN decoded for the ID instruction.
REQ-012 id_dest  in  REG_ADDR_LEN  destination register of the ID instruction.
REQ-013 branch_taken  in  1  a branch or jump is taken; squash the ID instruction.
REQ-014 hazard_detected  out  1  stall request to the controller, IF/ID hold and PC hold.
REQ-015 exe_dest  out  REG_ADDR_LEN  tracked EXE-stage destination (0 when the slot is a bubble).
REQ-016 mem_dest  out  REG_ADDR_LEN  tracked MEM-stage destination (0 when the slot is a bubble).
REQ-017 stall_cnt  out  CNT_LEN  number of cycles with hazard_detected=1 since reset.

Function
REQ-018 The unit SHALL keep two scoreboard slots, EXE and MEM, each holding {wb_en, mem_r_en, dest}.
REQ-019 WB-stage writes SHALL NOT be tracked, because the register file resolves same-cycle write/read internally.
REQ-020 Match rule: a source matches a slot when the source is nonzero, slot.wb_en=1 and slot.dest equals the source.
REQ-021 src2 SHALL participate in matching only when two_src=1.
REQ-022 Register 0 SHALL never produce a hazard.
REQ-023 With forward_en=0, the raw hazard SHALL be asserted when id_valid=1 and any participating source matches EXE or MEM.
REQ-024 With forward_en=1, the raw hazard SHALL be asserted only when id_valid=1, EXE.mem_r_en=1 and a participating source matches EXE (load-use).
REQ-025 hazard_detected SHALL equal raw hazard AND NOT branch_taken, combinationally, with zero-cycle latency.
REQ-026 Each clock, MEM SHALL load the current EXE slot.
REQ-027 Each clock, EXE SHALL load {id_wb_en, id_mem_r_en, id_dest} when id_valid=1, hazard_detected=0 and branch_taken=0.
REQ-028 Otherwise EXE SHALL load a bubble {0,0,0}.
REQ-029 When hazard and flush occur in the same cycle, the flush SHALL win: no stall, a bubble enters EXE, and stall_cnt does not increment.
REQ-030 stall_cnt SHALL increment by 1 on each clock where hazard_detected=1.
REQ-031 stall_cnt SHALL saturate at all-ones and SHALL NOT wrap.
REQ-032 A load-use stall SHALL last exactly 1 cycle with forward_en=1.
REQ-033 A dependent instruction SHALL stall exactly 2 cycles behind an adjacent producer, and 1 cycle with one instruction between them, with forward_en=0.
REQ-034 forward_en SHALL be sampled combinationally every cycle; a change mid-stall takes effect in that same cycle.

Reset
REQ-035 While rst=1 at a clock edge, both slots SHALL clear to bubbles and stall_cnt SHALL clear to 0.
REQ-036 After that edge, exe_dest=0, mem_dest=0 and hazard_detected=0 for any ID inputs until a producer is tracked.
REQ-037 A reset asserted mid-stall SHALL end the stall on the next edge.

Verification
REQ-038 Scenario 1: forward_en=0; ADD r3 followed by SUB r4,r3,r5 -> hazard_detected=1 for 2 cycles, stall_cnt=2, exe_dest=0 during the 2nd stall cycle, mem_dest=3 during the 2nd stall cycle.
REQ-039 Scenario 2: forward_en=1; LD r7 followed by ADD r1,r7,r2 -> 1 stall cycle. Repeat with an ADD producer instead of LD -> 0 stalls.
REQ-040 Scenario 3: producer writing r0 followed by a consumer reading r0 -> hazard_detected stays 0 and stall_cnt=0.
REQ-041 Scenario 4: ADDI r5 (two_src=0) followed by a consumer with src2=5 and two_src=0 -> no stall. The same consumer with two_src=1 -> stall.
REQ-042 Scenario 5: hazard condition with branch_taken=1 in the same cycle -> hazard_detected=0, exe_dest=0 on the next cycle, stall_cnt unchanged.
REQ-043 Scenario 6: preload stall_cnt near all-ones by forcing repeated stalls, then continue stalling -> stall_cnt holds at 16'hFFFF. Assert rst mid-stall -> stall_cnt=0, both slots cleared and hazard_detected=0 after 1 edge.
